// File: rtl/iir_pkg.sv
// Shared constants for the first-order IIR filter pair (forward filter and inverse).
// Both sides take their coefficients from here so they stay matched.
package iir_pkg;
  localparam int              IIR_WIDTH = 16;
  localparam int              IIR_A_MAG = 2;
  localparam int              IIR_B     = 3;
  localparam logic [15:0]     IIR_B_INV = 16'hAAAB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } iir_state_e;
endpackage

// File: rtl/iir_inverse_filter_if.sv
// Sample stream handshake: y samples in, recovered x samples out.
interface iir_inverse_filter_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] y_val;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] x_val;

  modport master (output in_valid, y_val, out_ready, input in_ready, out_valid, x_val);
  modport slave  (input in_valid, y_val, out_ready, output in_ready, out_valid, x_val);
endinterface

// File: rtl/seq_mul_mod.sv
// Shift-add multiplier, product truncated to WIDTH bits. One bit of b per cycle,
// WIDTH cycles after start; done is high during the final cycle and product is
// valid in that same cycle.
module seq_mul_mod #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] aq;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH-1:0] term;

  // aq is a shifted left once per cycle, so it pairs with b[cnt]
  assign term    = b[cnt] ? aq : '0;
  assign product = acc + term;
  assign done    = busy && (cnt == CW'(WIDTH - 1));

  // accumulate one partial product per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aq   <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (clear) begin
      busy <= 1'b0;
    end else if (start) begin
      aq   <= a;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      aq  <= aq << 1;
      acc <= product;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/iir_inverse_filter.sv
// Inverse of y(n) = -A_MAG*y(n-1) + B*x(n): x(n) = (y(n) + A_MAG*y(n-1)) * B^-1 mod 2^WIDTH.
// The division by B is a multiply by its modular inverse, done serially.
module iir_inverse_filter
  import iir_pkg::*;
#(
  parameter int               WIDTH = IIR_WIDTH,
  parameter int               A_MAG = IIR_A_MAG,
  parameter int               B     = IIR_B,
  parameter logic [WIDTH-1:0] B_INV = IIR_B_INV
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 clear,
  iir_inverse_filter_if.slave bus
);
  localparam logic [WIDTH-1:0] AM   = WIDTH'(A_MAG);
  localparam logic [WIDTH-1:0] BW   = WIDTH'(B);
  localparam logic [WIDTH-1:0] BCHK = BW * B_INV;

  if (BCHK != WIDTH'(1)) begin : g_bad_inv
    $error("iir_inverse_filter: B*B_INV is not 1 mod 2^WIDTH");
  end
  if (B % 2 == 0) begin : g_even_b
    $error("iir_inverse_filter: B must be odd");
  end

  iir_state_e       state, state_nxt;
  logic [WIDTH-1:0] y_prev;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] product;
  logic             start;
  logic             mul_done;

  assign num           = bus.y_val + AM * y_prev;
  assign bus.in_ready  = rst_n && !clear && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.x_val     = x_q;
  assign start         = bus.in_valid && bus.in_ready;

  seq_mul_mod #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .start   (start),
    .a       (num),
    .b       (B_INV),
    .done    (mul_done),
    .product (product)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state; clear overrides everything
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (mul_done) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // history advances only on an accepted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     y_prev <= '0;
    else if (clear) y_prev <= '0;
    else if (start) y_prev <= bus.y_val;
  end

  // result register, loaded once on the MUL->DONE transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          x_q <= '0;
    else if (clear)                      x_q <= '0;
    else if (state == MUL && mul_done)   x_q <= product;
  end
endmodule

// File: tb/tb_iir_inverse_filter.sv
// Directed bench for iir_inverse_filter: stream recovery, wrap-around,
// backpressure, clear and asynchronous reset.
module tb_iir_inverse_filter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  int   tests = 0;
  int   fails = 0;

  iir_inverse_filter_if #(.WIDTH(W)) bus ();

  iir_inverse_filter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer y until accepted; returns after the accept edge with in_valid dropped
  task automatic accept(input string tag, input int y);
    int n;
    bus.y_val    = W'(y);
    bus.in_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // count edges after the accept edge until out_valid shows
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // full transaction with out_ready high
  task automatic xfer(input string tag, input int y, input int x);
    int lat;
    accept(tag, y);
    wait_out(lat);
    chk({tag, "_lat"}, lat, W);
    chk({tag, "_x"}, int'(bus.x_val), x);
    tick();
    chk({tag, "_vld_drop"}, int'(bus.out_valid), 0);
    chk({tag, "_rdy_back"}, int'(bus.in_ready), 1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    #1;
    chk("clear_blocks_ready", int'(bus.in_ready), 0);
    tick();
    clear = 1'b0;
    #1;
  endtask

  initial begin
    int lat;
    bit seen;
    int yv[10] = '{18, 0, 18, -21, 69, -93, 219, -393, 819, -1596};
    int xv[10] = '{6, 12, 6, 5, 9, 15, 11, 15, 11, 14};

    rst_n = 1'b0;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.y_val     = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_x_val", int'(bus.x_val), 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", int'(bus.in_ready), 1);

    // main stream: x = (y + 2*y_prev) / 3
    for (int i = 0; i < 10; i++) xfer($sformatf("stream%0d", i), yv[i], xv[i]);

    // wrap-around: 20000 -> 28512, -15536 (num wraps) -> 30000
    pulse_clear();
    xfer("wrap0", 20000, 28512);
    xfer("wrap1", -15536, 30000);

    // backpressure in DONE
    pulse_clear();
    bus.out_ready = 1'b0;
    accept("bp", 18);
    wait_out(lat);
    chk("bp_lat", lat, W);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_vld", int'(bus.out_valid), 1);
      chk("bp_hold_x", int'(bus.x_val), 6);
      chk("bp_hold_rdy", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_vld", int'(bus.out_valid), 0);
    chk("bp_release_rdy", int'(bus.in_ready), 1);
    // history still holds y=18 after the stall: y=0 -> 12
    xfer("bp_hist", 0, 12);

    // clear during MUL: result discarded, history wiped
    accept("clrmul", 18);
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("clrmul_no_out", int'(seen), 0);
    xfer("clrmul_hist", 0, 0);

    // clear with in_valid in IDLE: nothing accepted
    bus.y_val    = W'(18);
    bus.in_valid = 1'b1;
    clear        = 1'b1;
    #1;
    chk("clridle_rdy", int'(bus.in_ready), 0);
    tick();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("clridle_no_out", int'(seen), 0);
    chk("clridle_rdy_after", int'(bus.in_ready), 1);

    // async reset mid-MUL
    accept("rstmul", 69);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmul_vld", int'(bus.out_valid), 0);
    chk("rstmul_rdy", int'(bus.in_ready), 0);
    tick();
    rst_n = 1'b1;
    #1;
    xfer("rstmul_after", 18, 6);

    // async reset in DONE: out_valid drops between edges
    bus.out_ready = 1'b0;
    accept("rstdone", 0);
    wait_out(lat);
    chk("rstdone_vld_before", int'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstdone_vld", int'(bus.out_valid), 0);
    chk("rstdone_x", int'(bus.x_val), 0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
